// File: rtl/exu_arb_pkg.sv
// Shared types and constants for the execute-port issue arbiter.
// The perf counters enabled by EXU_ARB_PERF_EN use PERF_CNT_W.
package exu_arb_pkg;

    localparam int N_REQ_DEF     = 4;
    localparam int PAYLOAD_W_DEF = 64;
    localparam int PERF_CNT_W    = 32;

    // Index width for an N-way requester set; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int IDX_W_DEF = idx_width(N_REQ_DEF);

    // Skid entry layout for the default configuration, shared with downstream decode.
    typedef struct packed {
        logic [PAYLOAD_W_DEF-1:0] payload;
        logic [IDX_W_DEF-1:0]     src;
    } skid_entry_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping.
// Reusable by any issue port that keeps its own rotating pointer.
module rr_arbiter
    import exu_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    logic [IW:0]   sum;
    logic [IW-1:0] cand;
    logic          found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            // ptr < N and k < N, so one conditional subtract gives (ptr+k) mod N.
            sum = {1'b0, ptr} + (IW+1)'(k);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end
            cand = sum[IW-1:0];
            if (en && !found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/exu_issue_arbiter.sv
// Round-robin arbiter sharing one ALU/BRU execute port, feeding a 2-entry skid buffer.
// Optional macro EXU_ARB_PERF_EN adds stall and conflict performance counters.
module exu_issue_arbiter
    import exu_arb_pkg::*;
#(
    parameter int N_REQ     = N_REQ_DEF,
    parameter int PAYLOAD_W = PAYLOAD_W_DEF,
    parameter int IDX_W     = idx_width(N_REQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*PAYLOAD_W-1:0] req_payload,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       exu_valid,
    output logic [PAYLOAD_W-1:0]       exu_payload,
    output logic [IDX_W-1:0]           exu_src,
    input  logic                       exu_ready,
    output logic                       busy
`ifdef EXU_ARB_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0]      perf_stall_cnt,
    output logic [PERF_CNT_W-1:0]      perf_conflict_cnt
`endif
);

    typedef struct packed {
        logic [PAYLOAD_W-1:0] payload;
        logic [IDX_W-1:0]     src;
    } entry_t;

    entry_t           skid_q [2];
    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic [IDX_W-1:0] rr_ptr_q;
    logic [IDX_W-1:0] rr_ptr_nxt;
    logic             head_q;
    logic             tail_q;

    logic             can_push;
    logic             push;
    logic             pop;
    logic [N_REQ-1:0] gnt;
    logic [IDX_W-1:0] gnt_idx;
    entry_t           push_entry;

    // Grant never looks at exu_ready; holding it in reset keeps req_ready low while rst is asserted.
    assign can_push = (count_q != 2'd2) & ~flush & rst;

    rr_arbiter #(
        .N  (N_REQ),
        .IW (IDX_W)
    ) u_rr_arbiter (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .en  (can_push),
        .gnt (gnt),
        .idx (gnt_idx)
    );

    assign req_ready = gnt;
    assign push      = |gnt;
    assign pop       = exu_valid & exu_ready;

    assign push_entry.payload = req_payload[int'(gnt_idx)*PAYLOAD_W +: PAYLOAD_W];
    assign push_entry.src     = gnt_idx;

    assign rr_ptr_nxt = (gnt_idx == IDX_W'(N_REQ-1)) ? '0 : gnt_idx + IDX_W'(1);

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        if (flush) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q  <= '0;
            rr_ptr_q <= '0;
            head_q   <= 1'b0;
            tail_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            if (push) begin
                rr_ptr_q <= rr_ptr_nxt;
            end
            if (flush) begin
                head_q <= 1'b0;
                tail_q <= 1'b0;
            end else begin
                if (push) tail_q <= ~tail_q;
                if (pop)  head_q <= ~head_q;
            end
        end
    end

    // Storage is cleared on reset so the head reads zero before the first push.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            skid_q[0] <= '0;
            skid_q[1] <= '0;
        end else if (push) begin
            skid_q[tail_q] <= push_entry;
        end
    end

    assign exu_valid   = (count_q != 2'd0);
    assign busy        = (count_q != 2'd0);
    assign exu_payload = skid_q[head_q].payload;
    assign exu_src     = skid_q[head_q].src;

`ifdef EXU_ARB_PERF_EN
    logic multi_req;

    assign multi_req = |(req_valid & (req_valid - N_REQ'(1)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_cnt    <= '0;
            perf_conflict_cnt <= '0;
        end else begin
            if (exu_valid & ~exu_ready) begin
                perf_stall_cnt <= perf_stall_cnt + PERF_CNT_W'(1);
            end
            if (push & multi_req) begin
                perf_conflict_cnt <= perf_conflict_cnt + PERF_CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_exu_issue_arbiter.sv
// Directed bench for exu_issue_arbiter; define EXU_ARB_PERF_EN to also cover the perf counters.
module tb_exu_issue_arbiter;

    localparam int N  = 4;
    localparam int PW = 64;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic [N-1:0]    req_valid;
    logic [N*PW-1:0] req_payload;
    logic [N-1:0]    req_ready;
    logic            exu_valid;
    logic [PW-1:0]   exu_payload;
    logic [IW-1:0]   exu_src;
    logic            exu_ready;
    logic            busy;
`ifdef EXU_ARB_PERF_EN
    logic [31:0]     perf_stall_cnt;
    logic [31:0]     perf_conflict_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    exu_issue_arbiter #(
        .N_REQ     (N),
        .PAYLOAD_W (PW)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .flush             (flush),
        .req_valid         (req_valid),
        .req_payload       (req_payload),
        .req_ready         (req_ready),
        .exu_valid         (exu_valid),
        .exu_payload       (exu_payload),
        .exu_src           (exu_src),
        .exu_ready         (exu_ready),
        .busy              (busy)
`ifdef EXU_ARB_PERF_EN
        ,
        .perf_stall_cnt    (perf_stall_cnt),
        .perf_conflict_cnt (perf_conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] pv(input int lane, input int tag);
        return {16'hA5A5, 16'(tag), 32'(lane)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b0;
        flush     = 1'b0;
        exu_ready = 1'b0;
        req_valid = '0;
        for (int i = 0; i < N; i++) req_payload[i*PW +: PW] = pv(i, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid",   64'(exu_valid),   64'(0));
        chk("rst_busy",    64'(busy),        64'(0));
        chk("rst_ready",   64'(req_ready),   64'(0));
        chk("rst_payload", 64'(exu_payload), 64'(0));
        chk("rst_src",     64'(exu_src),     64'(0));

        // Fill two entries, then reset mid-stream
        rst       = 1'b1;
        req_valid = 4'b1111;
        #1;
        chk("first_grant", 64'(req_ready), 64'(4'b0001));
        step();
        chk("fill_valid",   64'(exu_valid),   64'(1));
        chk("fill_src",     64'(exu_src),     64'(0));
        chk("fill_payload", 64'(exu_payload), pv(0, 0));
        chk("fill_grant1",  64'(req_ready),   64'(4'b0010));
        step();
        chk("full_busy",  64'(busy),      64'(1));
        chk("full_block", 64'(req_ready), 64'(0));
        rst = 1'b0;
        #1;
        chk("async_rst_valid", 64'(exu_valid), 64'(0));
        chk("async_rst_busy",  64'(busy),      64'(0));
        chk("async_rst_ready", 64'(req_ready), 64'(0));
        step();
        rst = 1'b1;
        #1;
        chk("post_rst_grant", 64'(req_ready), 64'(4'b0001));

        // Round-robin with all lanes requesting
        exu_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("rr_valid",   64'(exu_valid),   64'(1));
            chk("rr_src",     64'(exu_src),     64'(k % 4));
            chk("rr_payload", 64'(exu_payload), pv(k % 4, 0));
        end
        req_valid = '0;
        step();
        chk("rr_drain_valid", 64'(exu_valid), 64'(0));
        chk("rr_drain_busy",  64'(busy),      64'(0));

        // Backpressure with lanes 0 and 2
        exu_ready = 1'b0;
        req_valid = 4'b0101;
        #1;
        chk("bp_grant0", 64'(req_ready), 64'(4'b0001));
        step();
        chk("bp_src0", 64'(exu_src), 64'(0));
        req_payload[0*PW +: PW] = pv(0, 1);
        #1;
        chk("bp_grant2", 64'(req_ready), 64'(4'b0100));
        step();
        chk("bp_full_ready", 64'(req_ready),   64'(0));
        chk("bp_full_busy",  64'(busy),        64'(1));
        chk("bp_head_src",   64'(exu_src),     64'(0));
        chk("bp_head_pl",    64'(exu_payload), pv(0, 0));
        step();
        chk("bp_hold_src",   64'(exu_src),     64'(0));
        chk("bp_hold_pl",    64'(exu_payload), pv(0, 0));
        chk("bp_hold_ready", 64'(req_ready),   64'(0));
        exu_ready = 1'b1;
        #1;
        chk("bp_no_rdy_path", 64'(req_ready), 64'(0));
        step();
        chk("bp_drain_src2",  64'(exu_src),     64'(2));
        chk("bp_drain_pl2",   64'(exu_payload), pv(2, 0));
        chk("bp_resume",      64'(req_ready),   64'(4'b0001));
        step();
        chk("bp_new_head_src", 64'(exu_src),     64'(0));
        chk("bp_new_head_pl",  64'(exu_payload), pv(0, 1));
        req_valid = '0;
        step();
        chk("bp_empty", 64'(exu_valid), 64'(0));

        // Simultaneous push and pop at count 1
        req_valid = 4'b0010;
        #1;
        chk("pp_grant1", 64'(req_ready), 64'(4'b0010));
        step();
        req_valid = 4'b1000;
        #1;
        chk("pp_grant3", 64'(req_ready), 64'(4'b1000));
        step();
        chk("pp_valid", 64'(exu_valid),   64'(1));
        chk("pp_src",   64'(exu_src),     64'(3));
        chk("pp_pl",    64'(exu_payload), pv(3, 0));
        chk("pp_busy",  64'(busy),        64'(1));
        req_valid = '0;
        step();
        chk("pp_empty", 64'(exu_valid), 64'(0));

        // Flush with a full buffer and active requesters
        exu_ready = 1'b0;
        req_valid = 4'b0011;
        step();
        step();
        chk("fl_full_busy", 64'(busy), 64'(1));
        flush = 1'b1;
        #1;
        chk("fl_no_grant_full", 64'(req_ready), 64'(0));
        step();
        flush = 1'b0;
        chk("fl_valid", 64'(exu_valid), 64'(0));
        chk("fl_busy",  64'(busy),      64'(0));
        req_valid = 4'b0111;
        flush     = 1'b1;
        #1;
        chk("fl_no_grant_empty", 64'(req_ready), 64'(0));
        flush = 1'b0;
        #1;
        chk("fl_ptr_kept", 64'(req_ready), 64'(4'b0100));
        step();
        chk("fl_resume_src", 64'(exu_src),   64'(2));
        chk("fl_resume_vld", 64'(exu_valid), 64'(1));
        req_valid = '0;
        exu_ready = 1'b1;
        flush     = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_pop_valid", 64'(exu_valid), 64'(0));

`ifdef EXU_ARB_PERF_EN
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("perf_rst_stall", 64'(perf_stall_cnt),    64'(0));
        chk("perf_rst_conf",  64'(perf_conflict_cnt), 64'(0));
        exu_ready = 1'b0;
        req_valid = 4'b0011;
        step();
        step();
        req_valid = '0;
        step();
        step();
        exu_ready = 1'b1;
        step();
        step();
        chk("perf_stall", 64'(perf_stall_cnt),    64'(3));
        chk("perf_conf",  64'(perf_conflict_cnt), 64'(2));
        chk("perf_idle",  64'(exu_valid),         64'(0));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
